jelly_bit_packer: RTL

Packs variable-length bit fields into fixed-width words, LSB-first, with a valid/ready handshake on both sides. It sits directly downstream of the team's barrel-shift stage: the shifter right-justifies each field, and this block concatenates the fields into a continuous output word stream. Examples are variable-length code emission and bit-field serialisation.

---
 rtl/jelly_bit_packer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/jelly_bit_packer.sv
// jelly_bit_packer: concatenates right-justified variable-length fields into
// fixed-width words, LSB-first, with valid/ready on both sides.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// RUN    | accepting fields; words are emitted as they fill or on s_last
// FLUSH  | a last field overflowed; the residue word is emitted next
module jelly_bit_packer #(
    parameter int SHIFT_WIDTH = 4,
    parameter int DATA_WIDTH  = (1 << SHIFT_WIDTH),
    parameter int LEN_WIDTH   = SHIFT_WIDTH + 1
) (
    input  logic                  aresetn,
    input  logic                  aclk,
    input  logic                  aclken,
    input  logic [LEN_WIDTH-1:0]  s_len,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [LEN_WIDTH-1:0]  m_bits,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    typedef enum logic {ST_RUN, ST_FLUSH} state_t;

    localparam int                   ACC_WIDTH = 2 * DATA_WIDTH;
    localparam logic [LEN_WIDTH-1:0] DW_L      = LEN_WIDTH'(DATA_WIDTH);

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   fill_q, fill_d;
    logic [DATA_WIDTH-1:0]  m_data_q, m_data_d;
    logic [LEN_WIDTH-1:0]   m_bits_q, m_bits_d;
    logic                   m_last_q, m_last_d;
    logic                   m_valid_q, m_valid_d;

    logic                   free;
    logic                   accept;
    logic [LEN_WIDTH-1:0]   len_c;
    logic [DATA_WIDTH-1:0]  field;
    logic [ACC_WIDTH-1:0]   merged;
    logic [LEN_WIDTH-1:0]   new_fill;
    logic [LEN_WIDTH-1:0]   rem;

    assign free    = !m_valid_q || m_ready;
    // Gated by reset so nothing is offered while the block is held in reset.
    assign s_ready = aresetn && aclken && (state_q == ST_RUN) && free;
    assign accept  = s_valid && s_ready;

    // Clamp the length, mask the field and merge it above the current fill.
    always_comb begin
        len_c    = (s_len > DW_L) ? DW_L : s_len;
        // A shift by the full width yields zero, so len==DATA_WIDTH keeps every bit.
        field    = s_data & ~({DATA_WIDTH{1'b1}} << len_c);
        merged   = acc_q | ({{DATA_WIDTH{1'b0}}, field} << fill_q);
        new_fill = fill_q + len_c;
        rem      = new_fill - DW_L;
    end

    // Next-state and output-word selection.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        fill_d    = fill_q;
        m_data_d  = m_data_q;
        m_bits_d  = m_bits_q;
        m_last_d  = m_last_q;
        m_valid_d = m_valid_q;
        if (aclken && free) begin
            m_valid_d = 1'b0;
            if (state_q == ST_FLUSH) begin
                m_data_d  = acc_q[DATA_WIDTH-1:0];
                m_bits_d  = fill_q;
                m_last_d  = 1'b1;
                m_valid_d = 1'b1;
                acc_d     = '0;
                fill_d    = '0;
                state_d   = ST_RUN;
            end else if (accept) begin
                if (new_fill >= DW_L) begin
                    m_data_d  = merged[DATA_WIDTH-1:0];
                    m_bits_d  = DW_L;
                    m_valid_d = 1'b1;
                    m_last_d  = 1'b0;
                    acc_d     = merged >> DATA_WIDTH;
                    fill_d    = rem;
                    if (s_last) begin
                        if (rem != '0) begin
                            state_d = ST_FLUSH;
                        end else begin
                            m_last_d = 1'b1;
                            acc_d    = '0;
                            fill_d   = '0;
                        end
                    end
                end else if (s_last) begin
                    m_data_d  = merged[DATA_WIDTH-1:0];
                    m_bits_d  = new_fill;
                    m_last_d  = 1'b1;
                    m_valid_d = 1'b1;
                    acc_d     = '0;
                    fill_d    = '0;
                end else begin
                    acc_d  = merged;
                    fill_d = new_fill;
                end
            end
        end
    end

    // State and registered outputs; aclken low simply leaves every _d at _q.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_RUN;
            acc_q     <= '0;
            fill_q    <= '0;
            m_data_q  <= '0;
            m_bits_q  <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            fill_q    <= fill_d;
            m_data_q  <= m_data_d;
            m_bits_q  <= m_bits_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_bits  = m_bits_q;
    assign m_last  = m_last_q;
    assign m_valid = m_valid_q;

endmodule
